// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter subsystem: default width, monitor
// state encoding and the counter's next-state rule (clear handled by callers).
package counter_pkg;

  localparam int W = 8;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } mon_state_t;

  // Next counter value when clr is low: load beats counting, counting wraps mod 2^W.
  function automatic logic [W-1:0] next_count(
    input logic [W-1:0] count,
    input logic         ld,
    input logic [W-1:0] din,
    input logic         mode
  );
    if (ld)        return din;
    else if (mode) return count + W'(1);
    else           return count - W'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones, clears on clr.
module sat_counter #(
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            inc,
  output logic [ERRW-1:0] value
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr)
      value <= '0;
    else if (inc && (value != {ERRW{1'b1}}))
      value <= value + ERRW'(1);
  end

endmodule

// File: rtl/updown_count_monitor.sv
// Passive checker for the up/down counter: keeps a reference prediction re-seeded
// from the observed count every cycle, and flags mismatches, wraps and direction.
module updown_count_monitor
  import counter_pkg::*;
#(
  parameter int W       = counter_pkg::W,
  parameter int ERRW    = 8,
  parameter int MAX_ERR = 3
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            mode,
  input  logic            ld,
  input  logic [W-1:0]    din,
  input  logic [W-1:0]    count,
  output logic            locked,
  output logic            err,
  output logic [ERRW-1:0] err_cnt,
  output logic            wrap_up,
  output logic            wrap_dn,
  output logic            dir,
  output logic [W-1:0]    expected
);

  localparam int MW = $clog2(MAX_ERR + 1);

  mon_state_t    state, state_next;
  logic [MW-1:0] miss, miss_next;
  logic [W-1:0]  pred;
  logic          mismatch;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pred       = next_count(count, ld, din, mode);
    mismatch   = (state == TRACK) && (count != expected);
    state_next = state;
    miss_next  = miss;
    case (state)
      SYNC: begin
        state_next = TRACK;
        miss_next  = '0;
      end
      TRACK: begin
        if (mismatch) begin
          if (miss == MW'(MAX_ERR - 1)) begin
            state_next = SYNC;
            miss_next  = '0;
          end else begin
            miss_next = miss + MW'(1);
          end
        end else begin
          miss_next = '0;
        end
      end
      default: begin
        state_next = SYNC;
        miss_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= SYNC;
      miss     <= '0;
      expected <= '0;
      err      <= 1'b0;
      wrap_up  <= 1'b0;
      wrap_dn  <= 1'b0;
      dir      <= 1'b1;
    end else begin
      state    <= state_next;
      miss     <= miss_next;
      expected <= pred;
      err      <= mismatch;
      // A load never counts as a wrap, whatever din holds.
      wrap_up  <= !ld &&  mode && (count == {W{1'b1}});
      wrap_dn  <= !ld && !mode && (count == '0);
      if (!ld)
        dir <= mode;
    end
  end

  assign locked = (state == TRACK);

  sat_counter #(
    .ERRW (ERRW)
  ) u_err_cnt (
    .clk   (clk),
    .clr   (clr),
    .inc   (mismatch),
    .value (err_cnt)
  );

endmodule

// File: tb/tb_updown_count_monitor.sv
// Directed bench: a behavioural counter drives the observed bus (with an override
// for glitches/stuck faults) and monitor outputs are checked with hand values.
module tb_updown_count_monitor;

  logic       clk = 1'b0;
  logic       clr, mode, ld;
  logic [7:0] din, cnt, count, force_val;
  logic       force_en;
  logic       locked, err, wrap_up, wrap_dn, dir;
  logic [7:0] err_cnt, expected;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Observed counter; it advances from whatever is visible on the bus.
  assign count = force_en ? force_val : cnt;
  always @(posedge clk) begin
    if (clr)       cnt <= 8'h00;
    else if (ld)   cnt <= din;
    else if (mode) cnt <= count + 8'h01;
    else           cnt <= count - 8'h01;
  end

  updown_count_monitor #(
    .W       (8),
    .ERRW    (8),
    .MAX_ERR (3)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .mode     (mode),
    .ld       (ld),
    .din      (din),
    .count    (count),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt),
    .wrap_up  (wrap_up),
    .wrap_dn  (wrap_dn),
    .dir      (dir),
    .expected (expected)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; mode = 1'b1; ld = 1'b0; din = 8'h00;
    force_en = 1'b0; force_val = 8'h00;

    // Reset state
    step();
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_dir", dir, 1);
    check("rst_expected", expected, 0);
    check("rst_wrap_up", wrap_up, 0);
    check("rst_wrap_dn", wrap_dn, 0);

    // Up-count for 20 cycles
    clr = 1'b0;
    step();
    check("first_locked", locked, 1);
    check("first_expected", expected, 8'h01);
    check("first_count", count, 8'h01);
    for (int i = 0; i < 19; i++) begin
      step();
      check("up_err", err, 0);
      check("up_locked", locked, 1);
    end
    check("up_count", count, 8'h14);
    check("up_expected", expected, 8'h14);
    check("up_err_cnt", err_cnt, 0);
    check("up_dir", dir, 1);

    // Load 01 then count down through the 00->FF wrap
    ld = 1'b1; din = 8'h01;
    step();
    check("ld01_count", count, 8'h01);
    check("ld01_dir", dir, 1);
    ld = 1'b0; mode = 1'b0;
    step();
    check("dn_00_count", count, 8'h00);
    check("dn_00_wrap_dn", wrap_dn, 0);
    step();
    check("dn_ff_count", count, 8'hFF);
    check("dn_ff_wrap_dn", wrap_dn, 1);
    step();
    check("dn_fe_wrap_dn", wrap_dn, 0);
    check("dn_dir", dir, 0);
    check("dn_locked", locked, 1);
    check("dn_err_cnt", err_cnt, 0);

    // Up through FF->00, then load 00 from FF with mode low
    ld = 1'b1; din = 8'hFD; mode = 1'b1;
    step();
    ld = 1'b0;
    step();
    step();
    check("upw_ff_count", count, 8'hFF);
    check("upw_ff_wrap_up", wrap_up, 0);
    step();
    check("upw_00_count", count, 8'h00);
    check("upw_00_wrap_up", wrap_up, 1);
    step();
    check("upw_01_wrap_up", wrap_up, 0);
    ld = 1'b1; din = 8'hFF;
    step();
    check("ldff_count", count, 8'hFF);
    din = 8'h00; mode = 1'b0;
    step();
    check("ld00_count", count, 8'h00);
    check("ld00_wrap_up", wrap_up, 0);
    check("ld00_wrap_dn", wrap_dn, 0);
    check("ld00_dir_hold", dir, 1);
    check("ld00_err", err, 0);

    // Single glitch: 55 visible where 10 is expected
    din = 8'h0F; mode = 1'b1;
    step();
    ld = 1'b0;
    step();
    check("pre_glitch_expected", expected, 8'h10);
    force_en = 1'b1; force_val = 8'h55;
    check("glitch_err_same_cycle", err, 0);
    step();
    force_en = 1'b0;
    check("glitch_err", err, 1);
    check("glitch_err_cnt", err_cnt, 1);
    check("glitch_locked", locked, 1);
    check("glitch_expected", expected, 8'h56);
    step();
    check("glitch_err_clear", err, 0);
    check("glitch_err_cnt_hold", err_cnt, 1);
    check("glitch_locked_hold", locked, 1);

    // Mid-run clear
    clr = 1'b1;
    step();
    check("clr_err_cnt", err_cnt, 0);
    check("clr_locked", locked, 0);
    clr = 1'b0;
    step();
    check("clr_relock", locked, 1);

    // Persistent stuck-at AA for three cycles
    force_en = 1'b1; force_val = 8'hAA;
    step();
    check("stuck1_err", err, 1);
    check("stuck1_locked", locked, 1);
    step();
    check("stuck2_err", err, 1);
    check("stuck2_err_cnt", err_cnt, 2);
    step();
    force_en = 1'b0;
    check("stuck3_err", err, 1);
    check("stuck3_err_cnt", err_cnt, 3);
    check("stuck3_locked", locked, 0);
    step();
    check("resync_err", err, 0);
    check("resync_locked", locked, 1);
    check("resync_expected", expected, 8'hAC);
    step();
    check("tracked_err", err, 0);
    check("tracked_err_cnt", err_cnt, 3);

    // Saturation under a long stuck fault, then clear
    force_en = 1'b1; force_val = 8'hAA;
    for (int i = 0; i < 400; i++) step();
    force_en = 1'b0;
    check("sat_err_cnt", err_cnt, 8'hFF);
    step();
    check("sat_err_cnt_hold", err_cnt, 8'hFF);
    clr = 1'b1;
    step();
    check("satclr_err_cnt", err_cnt, 0);
    check("satclr_expected", expected, 0);
    check("satclr_locked", locked, 0);
    check("satclr_err", err, 0);
    clr = 1'b0;
    step();
    check("satclr_relock", locked, 1);
    check("satclr_expected1", expected, 8'h01);
    check("satclr_err_after", err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
